// File: rtl/pwm_pkg.sv
// Shared PWM types and parameter helpers.
// Holds the channel mode encoding and the prescaler divide computation.
package pwm_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    // Clocks per phase step; never below one.
    function automatic int presc_calc(
        input int clk_freq,
        input int pwm_freq,
        input int duty_w
    );
        int div;
        div = clk_freq / (pwm_freq * (1 << duty_w));
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler plus phase counter for the PWM bank.
// Ports: CLOCK_50, RESET_N in; tick, phase, period_end out.
module pwm_tick_gen #(
    parameter int PRESC  = 4,
    parameter int DUTY_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    output logic              tick,
    output logic [DUTY_W-1:0] phase,
    output logic              period_end
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0] cnt;

    assign tick       = (cnt == PW'(PRESC - 1));
    assign period_end = tick & (&phase);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt   <= '0;
            phase <= '0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with static, blink and breathe modes.
// Ports: CLOCK_50, RESET_N; write port wr_*; period_end, pwm_out.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int CLK_FREQ      = 50000000,
    parameter int PWM_FREQ      = 5000,
    parameter int CHANNELS      = 18,
    parameter int DUTY_W        = 8,
    parameter int BLINK_PERIODS = 2500,
    // One spare code so out-of-range indices stay representable
    // even when CHANNELS is a power of two.
    parameter int CH_W          = $clog2(CHANNELS + 1)
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [DUTY_W-1:0]   wr_duty,
    input  logic [1:0]          wr_mode,
    output logic                wr_err,
    output logic                period_end,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam int PRESC = presc_calc(CLK_FREQ, PWM_FREQ, DUTY_W);
    localparam int BW    = $clog2(BLINK_PERIODS + 1);
    localparam logic [DUTY_W-1:0] MAXL = '1;

    logic              tick;
    logic              pe;
    logic              boundary;
    logic [DUTY_W-1:0] phase;

    pwm_tick_gen #(
        .PRESC  (PRESC),
        .DUTY_W (DUTY_W)
    ) u_tick (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .tick       (tick),
        .phase      (phase),
        .period_end (pe)
    );

    assign period_end = pe;
    assign boundary   = tick & pe;

    logic [DUTY_W-1:0] sh_duty  [CHANNELS];
    mode_e             sh_mode  [CHANNELS];
    logic [DUTY_W-1:0] act_duty [CHANNELS];
    mode_e             act_mode [CHANNELS];
    logic [DUTY_W-1:0] nx_duty  [CHANNELS];
    mode_e             nx_mode  [CHANNELS];
    logic [BW-1:0]     blk_cnt  [CHANNELS];
    logic              blk_on   [CHANNELS];
    logic [DUTY_W-1:0] brt_lvl  [CHANNELS];
    logic              brt_up   [CHANNELS];
    logic [DUTY_W-1:0] lvl      [CHANNELS];

    logic wr_fire;
    logic wr_bad;
    logic wr_hit;

    assign wr_fire = wr_valid & wr_ready;
    assign wr_bad  = (32'(wr_ch) >= 32'(CHANNELS));
    assign wr_hit  = wr_fire & ~wr_bad;

    // Shadow as it will be after this cycle, so a write landing
    // on the boundary cycle is promoted with everything else.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            nx_duty[i] = sh_duty[i];
            nx_mode[i] = sh_mode[i];
            if (wr_hit && wr_ch == CH_W'(i)) begin
                nx_duty[i] = wr_duty;
                nx_mode[i] = mode_e'(wr_mode);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            lvl[i] = '0;
            case (act_mode[i])
                MODE_STATIC:  lvl[i] = act_duty[i];
                MODE_BLINK:   lvl[i] = blk_on[i] ? act_duty[i] : '0;
                MODE_BREATHE: lvl[i] = brt_lvl[i];
                default:      lvl[i] = '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ready <= 1'b0;
            wr_err   <= 1'b0;
            pwm_out  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_duty[i]  <= '0;
                sh_mode[i]  <= MODE_OFF;
                act_duty[i] <= '0;
                act_mode[i] <= MODE_OFF;
                blk_cnt[i]  <= '0;
                blk_on[i]   <= 1'b0;
                brt_lvl[i]  <= '0;
                brt_up[i]   <= 1'b0;
            end
        end else begin
            wr_ready <= 1'b1;
            wr_err   <= wr_fire & wr_bad;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_duty[i] <= nx_duty[i];
                sh_mode[i] <= nx_mode[i];
                // Full-scale level holds high through the wrap.
                pwm_out[i] <= (lvl[i] == MAXL) | (phase < lvl[i]);
                if (boundary) begin
                    act_duty[i] <= nx_duty[i];
                    act_mode[i] <= nx_mode[i];
                    if (nx_mode[i] != act_mode[i]) begin
                        blk_cnt[i] <= '0;
                        blk_on[i]  <= 1'b1;
                        brt_lvl[i] <= '0;
                        brt_up[i]  <= 1'b1;
                    end else begin
                        if (act_mode[i] == MODE_BLINK) begin
                            if (blk_cnt[i] + 1'b1 == BW'(BLINK_PERIODS)) begin
                                blk_cnt[i] <= '0;
                                blk_on[i]  <= ~blk_on[i];
                            end else begin
                                blk_cnt[i] <= blk_cnt[i] + 1'b1;
                            end
                        end
                        if (act_mode[i] == MODE_BREATHE) begin
                            if (brt_lvl[i] > nx_duty[i]) begin
                                // Duty fell under the ramp: clamp, head down.
                                brt_lvl[i] <= nx_duty[i];
                                brt_up[i]  <= 1'b0;
                            end else if (brt_up[i]) begin
                                if (brt_lvl[i] < nx_duty[i]) begin
                                    brt_lvl[i] <= brt_lvl[i] + 1'b1;
                                end else begin
                                    brt_up[i] <= 1'b0;
                                    if (brt_lvl[i] != '0)
                                        brt_lvl[i] <= brt_lvl[i] - 1'b1;
                                end
                            end else begin
                                if (brt_lvl[i] != '0) begin
                                    brt_lvl[i] <= brt_lvl[i] - 1'b1;
                                end else begin
                                    brt_up[i] <= 1'b1;
                                    if (nx_duty[i] != '0)
                                        brt_lvl[i] <= brt_lvl[i] + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank at a 4-channel, 4-bit, 64-clock period.
// Counts high clocks per channel over aligned period windows.
module tb_pwm_bank;

    localparam logic [1:0] M_STATIC  = 2'd0;
    localparam logic [1:0] M_BLINK   = 2'd1;
    localparam logic [1:0] M_BREATHE = 2'd2;

    logic       CLOCK_50;
    logic       RESET_N;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_ch;
    logic [3:0] wr_duty;
    logic [1:0] wr_mode;
    logic       wr_err;
    logic       period_end;
    logic [3:0] pwm_out;

    int checks;
    int errors;
    int hc [4][12];
    int pc [12];
    int n;
    int ones;
    int exp_b [9] = '{0, 4, 8, 12, 8, 4, 0, 4, 8};

    pwm_bank #(
        .CLK_FREQ      (16000),
        .PWM_FREQ      (250),
        .CHANNELS      (4),
        .DUTY_W        (4),
        .BLINK_PERIODS (2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_duty    (wr_duty),
        .wr_mode    (wr_mode),
        .wr_err     (wr_err),
        .period_end (period_end),
        .pwm_out    (pwm_out)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [3:0] d,
                            input logic [1:0] m);
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_duty  = d;
        wr_mode  = m;
        @(negedge CLOCK_50);
        wr_valid = 1'b0;
    endtask

    // Returns negedges waited until period_end; bounded.
    task automatic sync_pe(output int cnt);
        logic found;
        found = 1'b0;
        cnt   = 0;
        while (!found && cnt < 200) begin
            @(negedge CLOCK_50);
            cnt++;
            if (period_end) found = 1'b1;
        end
        check("sync_pe_found", 32'(found), 32'd1);
    endtask

    // Back-to-back 64-clock windows aligned to output periods.
    task automatic measure(input int np);
        for (int k = 0; k < np; k++) begin
            for (int c = 0; c < 4; c++) hc[c][k] = 0;
            pc[k] = 0;
            repeat (64) begin
                @(negedge CLOCK_50);
                for (int c = 0; c < 4; c++)
                    if (pwm_out[c]) hc[c][k]++;
                if (period_end) pc[k]++;
                wr_valid = 1'b0;
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        RESET_N  = 1'b0;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_duty  = '0;
        wr_mode  = '0;

        repeat (3) @(negedge CLOCK_50);
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_period_end", 32'(period_end), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);

        RESET_N = 1'b1;
        sync_pe(n);
        check("first_period_len", n, 63);
        check("wr_ready_up", 32'(wr_ready), 32'd1);

        do_write(3'd0, 4'd4, M_STATIC);
        do_write(3'd1, 4'd0, M_STATIC);
        do_write(3'd2, 4'd15, M_STATIC);
        sync_pe(n);
        @(negedge CLOCK_50);
        measure(2);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("static4_ch0_p%0d", k), hc[0][k], 16);
            check($sformatf("duty0_ch1_p%0d", k), hc[1][k], 0);
            check($sformatf("duty15_ch2_p%0d", k), hc[2][k], 64);
            check($sformatf("pe_count_p%0d", k), pc[k], 1);
        end

        do_write(3'd3, 4'd8, M_STATIC);
        ones = 0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (pwm_out[3]) ones++;
        end
        check("midwrite_old_duty", ones, 0);
        sync_pe(n);
        @(negedge CLOCK_50);
        measure(1);
        check("midwrite_new_duty", hc[3][0], 32);

        sync_pe(n);
        wr_valid = 1'b1;
        wr_ch    = 3'd3;
        wr_duty  = 4'd2;
        wr_mode  = M_STATIC;
        @(negedge CLOCK_50);
        wr_valid = 1'b0;
        measure(1);
        check("pe_cycle_write", hc[3][0], 8);
        check("ch0_still_16", hc[0][0], 16);

        do_write(3'd0, 4'd3, M_BREATHE);
        sync_pe(n);
        @(negedge CLOCK_50);
        measure(9);
        for (int k = 0; k < 9; k++)
            check($sformatf("breathe_p%0d", k), hc[0][k], exp_b[k]);

        wr_valid = 1'b1;
        wr_ch    = 3'd0;
        wr_duty  = 4'd0;
        wr_mode  = M_BREATHE;
        measure(3);
        check("clamp_cur", hc[0][0], 12);
        check("clamp_p1", hc[0][1], 0);
        check("clamp_p2", hc[0][2], 0);

        check("wr_err_idle", 32'(wr_err), 32'd0);
        wr_valid = 1'b1;
        wr_ch    = 3'd5;
        wr_duty  = 4'd15;
        wr_mode  = M_STATIC;
        @(negedge CLOCK_50);
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        wr_valid = 1'b0;
        @(negedge CLOCK_50);
        check("wr_err_drop", 32'(wr_err), 32'd0);
        sync_pe(n);
        @(negedge CLOCK_50);
        measure(1);
        check("bad_wr_ch0", hc[0][0], 0);
        check("bad_wr_ch1", hc[1][0], 0);
        check("bad_wr_ch2", hc[2][0], 64);
        check("bad_wr_ch3", hc[3][0], 8);

        do_write(3'd1, 4'd15, M_BLINK);
        sync_pe(n);
        @(negedge CLOCK_50);
        measure(4);
        check("blink_p0", hc[1][0], 64);
        check("blink_p1", hc[1][1], 64);
        check("blink_p2", hc[1][2], 0);
        check("blink_p3", hc[1][3], 0);

        repeat (10) @(negedge CLOCK_50);
        check("pre_reset_ch2", 32'(pwm_out[2]), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_ready", 32'(wr_ready), 32'd0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        sync_pe(n);
        check("rerelease_len", n, 63);
        @(negedge CLOCK_50);
        measure(1);
        for (int c = 0; c < 4; c++)
            check($sformatf("post_rst_off_ch%0d", c), hc[c][0], 0);

        do_write(3'd2, 4'd15, M_STATIC);
        sync_pe(n);
        @(negedge CLOCK_50);
        measure(1);
        check("rewrite_ch2", hc[2][0], 64);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
